ahbmtx_l1_in_stg: RTL and testbench

AHBMTX_L1_IN_STG -- requirements
Module: ahbmtx_l1_in_stg

---
 rtl/ahbmtx_l1_in_stg.sv | 132 +++++++++++++
 tb/tb_ahbmtx_l1_in_stg.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahbmtx_l1_in_stg.sv
// AHB matrix input stage: registers an address phase the output stage cannot take
// yet, and tracks which port owns the current slave data phase.
module ahbmtx_l1_in_stg (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSELS,
  input  logic [31:0] HADDRS,
  input  logic [31:0] HAUSERS,
  input  logic [1:0]  HTRANSS,
  input  logic        HWRITES,
  input  logic [2:0]  HSIZES,
  input  logic [2:0]  HBURSTS,
  input  logic [3:0]  HPROTS,
  input  logic [3:0]  HMASTERS,
  input  logic        HMASTLOCKS,
  input  logic        HREADYS,
  output logic        HREADYOUTS,
  output logic [1:0]  HRESPS,
  output logic        sel_ip,
  output logic [31:0] addr_ip,
  output logic [31:0] auser_ip,
  output logic [1:0]  trans_ip,
  output logic        write_ip,
  output logic [2:0]  size_ip,
  output logic [2:0]  burst_ip,
  output logic [3:0]  prot_ip,
  output logic [3:0]  master_ip,
  output logic        mastlock_ip,
  output logic        held_tran_ip,
  input  logic        active_ip,
  input  logic        readyout_ip,
  input  logic [1:0]  resp_ip
);

  logic        addr_valid;
  logic        accept;
  logic        capture;
  logic        issue;
  logic        hold_reg;
  logic        data_phase;

  logic        h_sel;
  logic [31:0] h_addr;
  logic [31:0] h_auser;
  logic [1:0]  h_trans;
  logic        h_write;
  logic [2:0]  h_size;
  logic [2:0]  h_burst;
  logic [3:0]  h_prot;
  logic [3:0]  h_master;
  logic        h_mastlock;

  assign addr_valid = HSELS & HTRANSS[1] & HREADYS;
  assign accept     = active_ip & readyout_ip;
  assign capture    = ~hold_reg & addr_valid & ~accept;
  // A transfer enters the data phase either from the holding regs or straight through.
  assign issue      = accept & (hold_reg | addr_valid);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hold_reg   <= 1'b0;
      data_phase <= 1'b0;
    end else begin
      if (capture)
        hold_reg <= 1'b1;
      else if (hold_reg && accept)
        hold_reg <= 1'b0;

      if (issue)
        data_phase <= 1'b1;
      else if (readyout_ip)
        data_phase <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      h_sel      <= 1'b0;
      h_addr     <= 32'h0;
      h_auser    <= 32'h0;
      h_trans    <= 2'b00;
      h_write    <= 1'b0;
      h_size     <= 3'b000;
      h_burst    <= 3'b000;
      h_prot     <= 4'h0;
      h_master   <= 4'h0;
      h_mastlock <= 1'b0;
    end else if (capture) begin
      h_sel      <= HSELS;
      h_addr     <= HADDRS;
      h_auser    <= HAUSERS;
      h_trans    <= HTRANSS;
      h_write    <= HWRITES;
      h_size     <= HSIZES;
      h_burst    <= HBURSTS;
      h_prot     <= HPROTS;
      h_master   <= HMASTERS;
      h_mastlock <= HMASTLOCKS;
    end
  end

  always_comb begin
    sel_ip      = HSELS;
    addr_ip     = HADDRS;
    auser_ip    = HAUSERS;
    trans_ip    = HREADYS ? HTRANSS : 2'b00;
    write_ip    = HWRITES;
    size_ip     = HSIZES;
    burst_ip    = HBURSTS;
    prot_ip     = HPROTS;
    master_ip   = HMASTERS;
    mastlock_ip = HMASTLOCKS;
    if (hold_reg) begin
      sel_ip      = h_sel;
      addr_ip     = h_addr;
      auser_ip    = h_auser;
      // Another port may have been granted in between, so a held SEQ restarts as NONSEQ.
      trans_ip    = (h_trans == 2'b11) ? 2'b10 : h_trans;
      write_ip    = h_write;
      size_ip     = h_size;
      burst_ip    = h_burst;
      prot_ip     = h_prot;
      master_ip   = h_master;
      mastlock_ip = h_mastlock;
    end
  end

  assign held_tran_ip = hold_reg | addr_valid;
  assign HREADYOUTS   = data_phase ? readyout_ip : ~hold_reg;
  assign HRESPS       = data_phase ? resp_ip : 2'b00;

endmodule

// File: tb/tb_ahbmtx_l1_in_stg.sv
// Directed bench for ahbmtx_l1_in_stg: pass-through, capture, held SEQ,
// ERROR response, data-phase/capture overlap and reset mid-hold.
module tb_ahbmtx_l1_in_stg;

  logic        HCLK;
  logic        HRESETn;
  logic        HSELS;
  logic [31:0] HADDRS;
  logic [31:0] HAUSERS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic [3:0]  HMASTERS;
  logic        HMASTLOCKS;
  logic        HREADYS;
  logic        HREADYOUTS;
  logic [1:0]  HRESPS;
  logic        sel_ip;
  logic [31:0] addr_ip;
  logic [31:0] auser_ip;
  logic [1:0]  trans_ip;
  logic        write_ip;
  logic [2:0]  size_ip;
  logic [2:0]  burst_ip;
  logic [3:0]  prot_ip;
  logic [3:0]  master_ip;
  logic        mastlock_ip;
  logic        held_tran_ip;
  logic        active_ip;
  logic        readyout_ip;
  logic [1:0]  resp_ip;

  int checks;
  int failures;

  ahbmtx_l1_in_stg dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HSELS(HSELS), .HADDRS(HADDRS), .HAUSERS(HAUSERS), .HTRANSS(HTRANSS),
    .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS),
    .HMASTERS(HMASTERS), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
    .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
    .sel_ip(sel_ip), .addr_ip(addr_ip), .auser_ip(auser_ip), .trans_ip(trans_ip),
    .write_ip(write_ip), .size_ip(size_ip), .burst_ip(burst_ip), .prot_ip(prot_ip),
    .master_ip(master_ip), .mastlock_ip(mastlock_ip), .held_tran_ip(held_tran_ip),
    .active_ip(active_ip), .readyout_ip(readyout_ip), .resp_ip(resp_ip)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Move to just after the next rising edge, where new inputs are applied.
  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic master_idle();
    HSELS = 1'b0; HADDRS = 32'h0; HAUSERS = 32'h0; HTRANSS = 2'b00;
    HWRITES = 1'b0; HSIZES = 3'b0; HBURSTS = 3'b0; HPROTS = 4'h0;
    HMASTERS = 4'h0; HMASTLOCKS = 1'b0; HREADYS = 1'b1;
  endtask

  task automatic master_xfer(input logic [31:0] a, input logic [1:0] t, input logic w,
                             input logic [2:0] b);
    HSELS = 1'b1; HADDRS = a; HTRANSS = t; HWRITES = w; HBURSTS = b; HREADYS = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    master_idle();
    active_ip = 1'b0; readyout_ip = 1'b1; resp_ip = 2'b00;
    HRESETn = 1'b0;
    #3;
    chk("rst_hreadyout", HREADYOUTS, 1);
    chk("rst_hresp", HRESPS, 0);
    chk("rst_held", held_tran_ip, 0);
    chk("rst_trans", trans_ip, 0);
    step(); step();
    HRESETn = 1'b1;

    // Pass-through
    step();
    master_xfer(32'h2000_0040, 2'b10, 1'b0, 3'b000);
    active_ip = 1'b1; readyout_ip = 1'b1;
    #1;
    chk("pt_trans", trans_ip, 2'b10);
    chk("pt_addr", addr_ip, 32'h2000_0040);
    chk("pt_hreadyout", HREADYOUTS, 1);
    chk("pt_held", held_tran_ip, 1);
    step();
    master_idle(); active_ip = 1'b0; readyout_ip = 1'b0;
    #1;
    chk("pt_dphase", HREADYOUTS, 0);
    chk("pt_no_capture", trans_ip, 2'b00);
    step();
    readyout_ip = 1'b1;
    #1;
    chk("pt_dphase_end", HREADYOUTS, 1);
    step();
    readyout_ip = 1'b0;
    #1;
    chk("pt_dphase_clr", HREADYOUTS, 1);

    // Live path with HREADYS low presents IDLE
    master_xfer(32'h2000_0050, 2'b10, 1'b0, 3'b000);
    HREADYS = 1'b0;
    #1;
    chk("hreadys_lo_trans", trans_ip, 2'b00);
    chk("hreadys_lo_held", held_tran_ip, 0);

    // Capture with master changing inputs while held
    step();
    master_xfer(32'h2000_0080, 2'b10, 1'b1, 3'b000);
    HAUSERS = 32'hA5A5_0001; HSIZES = 3'b010; HPROTS = 4'h3; HMASTERS = 4'h5;
    HMASTLOCKS = 1'b1;
    active_ip = 1'b0; readyout_ip = 1'b1;
    #1;
    chk("cap_first_hreadyout", HREADYOUTS, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      HADDRS = 32'h2000_0084; HWRITES = 1'b0; HAUSERS = 32'h0; HSIZES = 3'b0;
      HPROTS = 4'h0; HMASTERS = 4'h0; HMASTLOCKS = 1'b0; HTRANSS = 2'b00;
      #1;
      chk("cap_addr", addr_ip, 32'h2000_0080);
      chk("cap_hreadyout", HREADYOUTS, 0);
      chk("cap_held", held_tran_ip, 1);
      chk("cap_trans", trans_ip, 2'b10);
    end
    chk("cap_write", write_ip, 1);
    chk("cap_auser", auser_ip, 32'hA5A5_0001);
    chk("cap_size", size_ip, 3'b010);
    chk("cap_prot", prot_ip, 4'h3);
    chk("cap_master", master_ip, 4'h5);
    chk("cap_lock", mastlock_ip, 1);
    chk("cap_sel", sel_ip, 1);
    step();
    active_ip = 1'b1; readyout_ip = 1'b1;
    #1;
    chk("acc_addr", addr_ip, 32'h2000_0080);
    chk("acc_hreadyout", HREADYOUTS, 0);
    step();
    master_idle(); active_ip = 1'b0;
    #1;
    chk("acc_done_hreadyout", HREADYOUTS, 1);
    chk("acc_done_held", held_tran_ip, 0);
    chk("acc_done_addr", addr_ip, 32'h0);

    // Held SEQ restarts as NONSEQ, next live SEQ passes untouched
    step();
    master_xfer(32'h2000_0104, 2'b11, 1'b0, 3'b011);
    active_ip = 1'b0; readyout_ip = 1'b1;
    #1;
    chk("seq_live", trans_ip, 2'b11);
    step();
    HADDRS = 32'h2000_0108;
    #1;
    chk("seq_held_trans", trans_ip, 2'b10);
    chk("seq_held_addr", addr_ip, 32'h2000_0104);
    chk("seq_held_burst", burst_ip, 3'b011);
    step();
    active_ip = 1'b1;
    #1;
    chk("seq_acc_trans", trans_ip, 2'b10);
    step();
    #1;
    chk("seq_next_trans", trans_ip, 2'b11);
    chk("seq_next_addr", addr_ip, 32'h2000_0108);
    chk("seq_next_hreadyout", HREADYOUTS, 1);
    step();
    master_idle(); active_ip = 1'b0;
    step();

    // Two-cycle ERROR response
    master_xfer(32'h2000_0200, 2'b10, 1'b0, 3'b000);
    active_ip = 1'b1; readyout_ip = 1'b1;
    step();
    master_idle(); active_ip = 1'b0; readyout_ip = 1'b0; resp_ip = 2'b01;
    #1;
    chk("err1_resp", HRESPS, 2'b01);
    chk("err1_hreadyout", HREADYOUTS, 0);
    step();
    readyout_ip = 1'b1;
    #1;
    chk("err2_resp", HRESPS, 2'b01);
    chk("err2_hreadyout", HREADYOUTS, 1);
    chk("err2_held", held_tran_ip, 0);
    step();
    #1;
    chk("err_after_resp", HRESPS, 2'b00);
    resp_ip = 2'b00;

    // Data phase ends while a new unaccepted transfer arrives
    master_xfer(32'h2000_0300, 2'b10, 1'b0, 3'b000);
    active_ip = 1'b1; readyout_ip = 1'b1;
    step();
    master_xfer(32'h2000_0400, 2'b10, 1'b1, 3'b000);
    active_ip = 1'b0; readyout_ip = 1'b1;
    #1;
    chk("ovl_dphase_ready", HREADYOUTS, 1);
    step();
    #1;
    chk("ovl_hreadyout", HREADYOUTS, 0);
    chk("ovl_addr", addr_ip, 32'h2000_0400);
    chk("ovl_resp", HRESPS, 2'b00);

    // Asynchronous reset while holding
    master_idle();
    #1;
    chk("pre_rst_held", held_tran_ip, 1);
    HRESETn = 1'b0;
    #1;
    chk("mid_rst_held", held_tran_ip, 0);
    chk("mid_rst_hreadyout", HREADYOUTS, 1);
    chk("mid_rst_trans", trans_ip, 2'b00);
    step();
    HRESETn = 1'b1;
    active_ip = 1'b1; readyout_ip = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_trans", trans_ip, 2'b00);
      chk("post_rst_held", held_tran_ip, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
